// File: rtl/scrub_pkg.sv
// Shared definitions for the ECC scrubber: FSM states, SEC code columns and helpers.
// Each data bit owns a distinct weight-3 syndrome so a lone check-bit flip never aliases a data bit.
package scrub_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CHK,
        WB,
        ADV,
        DONE
    } state_e;

    // Column j is the check-bit pattern contributed by data bit j.
    localparam logic [CHK_W-1:0] H_COL [DATA_W] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62
    };

    function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] c;
        c = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (data[j]) begin
                c = c ^ H_COL[j];
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sec32_correct.sv
// Combinational single-error corrector for one 32-bit word and its 8 check bits.
// A syndrome matching a data-bit column is repaired; any other nonzero syndrome is only flagged.
module sec32_correct
    import scrub_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [CHK_W-1:0]  check,
    input  logic              enable,
    output logic [DATA_W-1:0] data_out,
    output logic [CHK_W-1:0]  check_out,
    output logic              syn_nz,
    output logic              corrected
);

    logic [CHK_W-1:0]  syndrome;
    logic [DATA_W-1:0] flip;

    always_comb begin
        syndrome = calc_check(data) ^ check;
        flip     = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (syndrome == H_COL[j]) begin
                flip[j] = 1'b1;
            end
        end
        syn_nz    = enable && (syndrome != '0);
        corrected = enable && (flip != '0);
        data_out  = enable ? (data ^ flip) : '0;
        check_out = enable ? calc_check(data ^ flip) : '0;
    end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background ECC scrubber: reads every word, repairs single data-bit errors by write-back,
// and counts corrected and uncorrectable words. Yields the memory whenever the host is busy.
module ecc_scrub_ctrl
    import scrub_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 2**ADDR_W-1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              host_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CHK_W-1:0]  mem_wcheck,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [CHK_W-1:0]  mem_rcheck,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  unc_cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CHK_W-1:0]  wcheck_q, wcheck_d;
    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  unc_cnt_q, unc_cnt_d;

    logic [DATA_W-1:0] fix_data;
    logic [CHK_W-1:0]  fix_check;
    logic              fix_syn_nz;
    logic              fix_corrected;
    logic              req_ok;

    sec32_correct u_sec (
        .data      (mem_rdata),
        .check     (mem_rcheck),
        .enable    (state_q == CHK),
        .data_out  (fix_data),
        .check_out (fix_check),
        .syn_nz    (fix_syn_nz),
        .corrected (fix_corrected)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            wcheck_q   <= '0;
            corr_cnt_q <= '0;
            unc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            wcheck_q   <= wcheck_d;
            corr_cnt_q <= corr_cnt_d;
            unc_cnt_q  <= unc_cnt_d;
        end
    end

    // The request is withdrawn combinationally while the host owns memory; state simply waits.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        wcheck_d   = wcheck_q;
        corr_cnt_d = corr_cnt_q;
        unc_cnt_d  = unc_cnt_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        req_ok     = !host_busy;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD;
                    mem_addr_d = '0;
                    corr_cnt_d = '0;
                    unc_cnt_d  = '0;
                end
            end
            RD: begin
                mem_req = req_ok;
                if (req_ok && mem_gnt) begin
                    state_d = CHK;
                end
            end
            CHK: begin
                if (fix_corrected) begin
                    state_d    = WB;
                    wdata_d    = fix_data;
                    wcheck_d   = fix_check;
                    corr_cnt_d = sat_inc(corr_cnt_q);
                end else begin
                    state_d = ADV;
                    if (fix_syn_nz) begin
                        unc_cnt_d = sat_inc(unc_cnt_q);
                    end
                end
            end
            WB: begin
                mem_req = req_ok;
                mem_we  = 1'b1;
                if (req_ok && mem_gnt) begin
                    state_d = ADV;
                end
            end
            ADV: begin
                if (mem_addr_q == LAST) begin
                    state_d = DONE;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    state_d    = RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wcheck = wcheck_q;
    assign busy       = (state_q != IDLE);
    assign corr_cnt   = corr_cnt_q;
    assign unc_cnt    = unc_cnt_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Self-checking bench for ecc_scrub_ctrl: a behavioural memory plus a sweep-level outcome model
// (which words get read, which get rewritten, final counts and latency) compared against the DUT.
module tb_ecc_scrub_ctrl;

    localparam int ADDR_W    = 4;
    localparam int LAST_ADDR = 3;
    localparam int NWORDS    = LAST_ADDR + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              host_busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [7:0]        mem_wcheck;
    logic              mem_gnt;
    logic [31:0]       mem_rdata;
    logic [7:0]        mem_rcheck;
    logic              busy;
    logic              done;
    logic [15:0]       corr_cnt;
    logic [15:0]       unc_cnt;

    always #5 clk = ~clk;

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .host_busy  (host_busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wcheck (mem_wcheck),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rcheck (mem_rcheck),
        .busy       (busy),
        .done       (done),
        .corr_cnt   (corr_cnt),
        .unc_cnt    (unc_cnt)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [7:0]  chk;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  colTab [32];
    logic [31:0] memData [NWORDS];
    logic [7:0]  memChk [NWORDS];
    int          readLog [$];
    wr_t         wrLog [$];
    wr_t         wrExp [$];

    int          gntPct, hostPct, hostLo, hostHi, hostAddrExp, midStartRel, forceRel, rstRel, expLat;
    int          corrBase;
    bit          rstNext, startNext, hostNext, gntNext;
    int          cycle = 0;
    bit          rdPending = 1'b0;
    int          rdAddr = 0;
    bit          prevStall = 1'b0;
    logic [ADDR_W-1:0] prevAddr;
    logic        prevWe;
    logic [31:0] prevWdata;
    logic [7:0]  prevWcheck;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // The code: data bit j flips the j-th smallest byte value having exactly three ones.
    function automatic void buildColumns();
        int n;
        n = 0;
        for (int v = 1; v < 256; v++) begin
            if ($countones(v) == 3 && n < 32) begin
                colTab[n] = 8'(v);
                n++;
            end
        end
    endfunction

    function automatic logic [7:0] modelCheck(input logic [31:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) c = c ^ colTab[j];
        end
        return c;
    endfunction

    function automatic int satAdd(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic defaultKnobs();
        gntPct = 100; hostPct = 0; hostLo = -1; hostHi = -2; hostAddrExp = -1;
        midStartRel = -1; forceRel = -5; rstRel = -1; expLat = -1; corrBase = 0;
    endtask

    // One clock: drive inputs at the falling edge, observe settled outputs, play the memory side.
    task automatic applyStimulus();
        int a;
        @(negedge clk);
        if (rdPending) begin
            mem_rdata  = memData[rdAddr];
            mem_rcheck = memChk[rdAddr];
            rdPending  = 1'b0;
        end
        rst       = rstNext;
        start     = startNext;
        host_busy = hostNext;
        mem_gnt   = gntNext;
        #1;
        cycle++;
        if (host_busy) checkOutput("reqWhileHostBusy", 32'(mem_req), 32'd0);
        if (prevStall && mem_req) begin
            checkOutput("stallAddr", 32'(mem_addr), 32'(prevAddr));
            checkOutput("stallWe", 32'(mem_we), 32'(prevWe));
            checkOutput("stallWdata", mem_wdata, prevWdata);
            checkOutput("stallWcheck", 32'(mem_wcheck), 32'(prevWcheck));
        end
        prevStall  = mem_req && !mem_gnt;
        prevAddr   = mem_addr;
        prevWe     = mem_we;
        prevWdata  = mem_wdata;
        prevWcheck = mem_wcheck;
        if (mem_req && mem_gnt) begin
            a = int'(mem_addr);
            if (mem_we) begin
                wrLog.push_back(wr_t'{a, mem_wdata, mem_wcheck});
                if (a < NWORDS) begin
                    memData[a] = mem_wdata;
                    memChk[a]  = mem_wcheck;
                end
            end else begin
                readLog.push_back(a);
                rdPending = (a < NWORDS);
                rdAddr    = (a < NWORDS) ? a : 0;
            end
        end
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "Req"}, 32'(mem_req), 32'd0);
        checkOutput({pfx, "We"}, 32'(mem_we), 32'd0);
        checkOutput({pfx, "Addr"}, 32'(mem_addr), 32'd0);
        checkOutput({pfx, "Wdata"}, mem_wdata, 32'd0);
        checkOutput({pfx, "Wcheck"}, 32'(mem_wcheck), 32'd0);
        checkOutput({pfx, "Busy"}, 32'(busy), 32'd0);
        checkOutput({pfx, "Done"}, 32'(done), 32'd0);
        checkOutput({pfx, "Corr"}, 32'(corr_cnt), 32'd0);
        checkOutput({pfx, "Unc"}, 32'(unc_cnt), 32'd0);
    endtask

    // Predict the sweep outcome from the memory image, launch it, then compare.
    task automatic runSweep();
        int          startCycle, doneRel, expCorr, expUnc, fixBit;
        logic [7:0]  syn;
        logic [31:0] d;
        readLog.delete();
        wrLog.delete();
        wrExp.delete();
        expCorr = corrBase;
        expUnc  = 0;
        for (int a = 0; a < NWORDS; a++) begin
            syn = modelCheck(memData[a]) ^ memChk[a];
            if (syn != 8'h00) begin
                fixBit = -1;
                for (int j = 0; j < 32; j++) if (colTab[j] == syn) fixBit = j;
                if (fixBit >= 0) begin
                    d = memData[a] ^ (32'd1 << fixBit);
                    wrExp.push_back(wr_t'{a, d, modelCheck(d)});
                    expCorr = satAdd(expCorr);
                end else begin
                    expUnc = satAdd(expUnc);
                end
            end
        end

        startNext = 1'b1; hostNext = 1'b0; gntNext = 1'b0;
        applyStimulus();
        startCycle = cycle;
        doneRel = -1;
        for (int rel = 1; rel <= 3000 && doneRel < 0; rel++) begin
            hostNext  = (rel >= hostLo && rel <= hostHi) || ($urandom_range(99) < 32'(hostPct));
            gntNext   = ($urandom_range(99) < 32'(gntPct));
            startNext = (rel == midStartRel);
            rstNext   = (rel == rstRel);
            applyStimulus();
            if (rstNext) begin
                checkResetOutputs("rstMidSweep");
                checkOutput("rstNoWrite", 32'(wrLog.size()), 32'd0);
                rstNext = 1'b0; startNext = 1'b0; hostNext = 1'b0; gntNext = 1'b1;
                applyStimulus();
                checkOutput("rstStaysIdle", 32'(busy), 32'd0);
                checkOutput("rstNoAccess", 32'(mem_req), 32'd0);
                return;
            end
            if (hostAddrExp >= 0 && host_busy) checkOutput("addrHeld", 32'(mem_addr), 32'(hostAddrExp));
            checkOutput("busyInSweep", 32'(busy), 32'd1);
            if (rel == forceRel) force dut.corr_cnt_q = 16'hFFFD;
            if (rel == forceRel + 1) release dut.corr_cnt_q;
            if (done) doneRel = cycle - startCycle;
        end

        if (doneRel < 0) begin
            checkOutput("doneTimeout", 32'd0, 32'd1);
        end else begin
            if (expLat >= 0) checkOutput("doneLatency", 32'(doneRel), 32'(expLat));
            startNext = 1'b0; hostNext = 1'b0; gntNext = 1'b0;
            applyStimulus();
            checkOutput("donePulse", 32'(done), 32'd0);
            checkOutput("busyAfterDone", 32'(busy), 32'd0);
            checkOutput("corrCnt", 32'(corr_cnt), 32'(expCorr));
            checkOutput("uncCnt", 32'(unc_cnt), 32'(expUnc));
            checkOutput("readCount", 32'(readLog.size()), 32'(NWORDS));
            for (int i = 0; i < readLog.size() && i < NWORDS; i++)
                checkOutput("readAddr", 32'(readLog[i]), 32'(i));
            checkOutput("writeCount", 32'(wrLog.size()), 32'(wrExp.size()));
            for (int i = 0; i < wrLog.size() && i < wrExp.size(); i++) begin
                checkOutput("writeAddr", 32'(wrLog[i].addr), 32'(wrExp[i].addr));
                checkOutput("writeData", wrLog[i].data, wrExp[i].data);
                checkOutput("writeCheck", 32'(wrLog[i].chk), 32'(wrExp[i].chk));
            end
        end
    endtask

    task automatic corruptRandom();
        int k, b1, b2;
        for (int a = 0; a < NWORDS; a++) begin
            k  = int'($urandom_range(3));
            b1 = int'($urandom_range(31));
            b2 = (b1 + 1 + int'($urandom_range(30))) % 32;
            case (k)
                1: memData[a] = memData[a] ^ (32'd1 << b1);
                2: memChk[a]  = memChk[a] ^ (8'd1 << (b1 % 8));
                3: memData[a] = memData[a] ^ (32'd1 << b1) ^ (32'd1 << b2);
                default: ;
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; host_busy = 1'b0; mem_gnt = 1'b0;
        mem_rdata = 32'h0; mem_rcheck = 8'h0;
        rstNext = 1'b1; startNext = 1'b0; hostNext = 1'b0; gntNext = 1'b1;
        buildColumns();
        for (int a = 0; a < NWORDS; a++) begin
            memData[a] = $urandom;
            memChk[a]  = modelCheck(memData[a]);
        end
        defaultKnobs();

        applyStimulus();
        applyStimulus();
        checkResetOutputs("reset");
        rstNext = 1'b0; gntNext = 1'b0;
        applyStimulus();

        $display("[TB] clean sweep");
        expLat = 13;
        runSweep();

        $display("[TB] word 2 data bit 7 flipped");
        memData[2] = memData[2] ^ 32'h0000_0080;
        expLat = 14;
        runSweep();

        $display("[TB] word 1 check bit 0 flipped");
        memChk[1] = memChk[1] ^ 8'h01;
        expLat = 13;
        runSweep();
        memChk[1] = memChk[1] ^ 8'h01;

        $display("[TB] host busy during read of address 1");
        hostLo = 4; hostHi = 8; hostAddrExp = 1; expLat = 18;
        runSweep();
        defaultKnobs();

        $display("[TB] reset during write-back of address 2");
        memData[2] = memData[2] ^ 32'h0001_0000;
        rstRel = 9;
        runSweep();
        defaultKnobs();
        expLat = 14;
        runSweep();
        defaultKnobs();

        $display("[TB] counter saturation with stray start");
        for (int a = 0; a < NWORDS; a++) memData[a] = memData[a] ^ (32'd1 << $urandom_range(31));
        forceRel = 1; corrBase = 16'hFFFD; midStartRel = 5; expLat = 17;
        runSweep();
        defaultKnobs();

        $display("[TB] randomized sweeps");
        repeat (8) begin
            corruptRandom();
            gntPct = 60; hostPct = 25; midStartRel = int'($urandom_range(1, 20));
            runSweep();
            defaultKnobs();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
